regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between two writeback requesters: req0 (ALU/execute result) and req1 (memory load return). It performs round-robin arbitration with a valid/ready handshake. Winning writes are registered, so they reach the register file one cycle after acceptance. Writes aimed at $0 complete the handshake but are dropped and counted, because $0 is hardwired to 0x0000 and its bit cells have write enable tied low.

Parameters:
- DATA_W, 16, width of write data.
- ADDR_W, 4, register index width (16 registers).
- CNT_W, 8, width of the saturating dropped-write counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a write pending.
- req0_addr  in  ADDR_W  requester 0 destination register.
- req0_data  in  DATA_W  requester 0 write data.
- req0_ready  out  1  requester 0 write accepted this cycle (combinational).
- req1_valid, req1_addr, req1_data, req1_ready  same as requester 0, for requester 1.
- hold  in  1  blocks all acceptance (used during pipeline freeze).
- wr_en  out  1  register-file WriteEnable, registered.
- wr_addr  out  ADDR_W  register-file write address, registered.
- wr_data  out  DATA_W  register-file write data, registered.
- drop_cnt  out  CNT_W  number of $0 writes dropped, saturating.

Behaviour:
- Reset (rst=1 at a clock edge):
  - wr_en=0, wr_addr=0, wr_data=0, drop_cnt=0.
  - last-served pointer=1, so req0 wins the first contention.
  - While rst=1, both ready outputs are 0.
- Grant, combinational, evaluated only when rst=0 and hold=0:
  - Only reqN_valid=1: grant N.
  - Both valid: grant the requester other than last-served.
  - Neither valid: no grant.
  - reqN_ready=1 only for the granted N. At most one ready is high per cycle.
- Handshake: a transfer occurs when reqN_valid && reqN_ready. The requester must hold addr/data stable while valid=1 and ready=0.
- On a transfer from requester N:
  - last-served is set to N; it is updated only on a transfer.
  - Next cycle: wr_addr=reqN_addr and wr_data=reqN_data.
  - Next cycle: wr_en=1 if addr!=0, else wr_en=0 and drop_cnt increments, saturating at 2^CNT_W-1.
- No transfer in a cycle: next cycle wr_en=0; wr_addr and wr_data keep their values.
- Latency and throughput: acceptance to wr_en is exactly 1 cycle. Sustained throughput is one write per cycle, and wr_en never stays high longer than one cycle per transfer.
- hold=1: ready=0 for both requesters. A write accepted in the previous cycle still drives wr_en this cycle.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,... No requester waits more than 1 cycle once the other is also valid.
- Same destination from both requesters: serviced in grant order. The register file ends with the later-granted data.
- Reset mid-operation: a write accepted in the cycle rst rises is discarded, and wr_en=0 in the following cycle.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - Adds inputs rd_addr1, rd_addr2 (ADDR_W).
  - Adds outputs byp_hit1, byp_hit2 (1) and byp_data (DATA_W).
  - byp_hitK = wr_en && wr_addr==rd_addrK && rd_addrK!=0, combinational.
  - byp_data = wr_data.
  - The decode stage uses these to forward the in-flight write.
- Undefined: these ports and their logic are absent; register-file internal bypassing alone is relied upon.

Decomposition:
- Package regfile_pkg:
  - DATA_W and ADDR_W constants.
  - ZERO_REG = 4'h0.
  - typedef wb_req_t with fields valid, addr, data.
  - enum wb_src_e with values SRC_ALU=0, SRC_MEM=1.
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: clk, rst, req[1:0], advance.
  - Outputs: gnt[1:0] (one-hot or zero).
  - Owns the last-served flop.
  - Instantiated once inside regfile_wb_arbiter.

Test Plan:
- Reset then single request:
  - Stimulus: after rst, req0 valid, addr=3, data=0xBEEF for 1 cycle.
  - Response: req0_ready=1; next cycle wr_en=1, wr_addr=3, wr_data=0xBEEF; the cycle after, wr_en=0.
- Contention:
  - Stimulus: both valid for 4 cycles (req0 addr 5 / data 0x1111, req1 addr 6 / data 0x2222), each dropping valid after its accept.
  - Response: req0 accepted first, req1 on the next cycle; wr_en pulses 2 consecutive cycles, addr 5 then 6.
- $0 drop:
  - Stimulus: req1 writes addr=0, data=0xFFFF three times.
  - Response: three handshakes; wr_en stays 0; drop_cnt=3.
- hold:
  - Stimulus: hold=1 for 3 cycles with req0 valid (addr 7).
  - Response: req0_ready=0 throughout; acceptance in the first cycle after hold falls; wr_en one cycle later.
- Reset mid-flight:
  - Stimulus: req0 accepted (addr 9) in the same cycle rst=1.
  - Response: next cycle wr_en=0 and drop_cnt=0.
- WB_BYPASS_EN build:
  - Stimulus: rd_addr1=4 while the in-flight write is addr 4 / 0xCAFE.
  - Response: byp_hit1=1, byp_data=0xCAFE.
  - Stimulus: rd_addr2=0 while the in-flight write is addr 0.
  - Response: byp_hit2=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file writeback path.
//   DATA_W / ADDR_W : default write-data and register-index widths
//   ZERO_REG        : index of the hardwired-zero register ($0)
//   wb_req_t        : one writeback request (valid, destination, data)
//   wb_src_e        : identity of a writeback requester (ALU or memory)
//   is_zero_reg()   : true when a destination index names $0
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    localparam logic [ADDR_W-1:0] ZERO_REG = 4'h0;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return (addr == ZERO_REG);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. Holds the last-served flop; when both
// requesters are pending, the one not served last wins.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset (last-served -> requester 1,
//                 so requester 0 wins the first contention)
//   req      in   [1:0] pending requests (already qualified by the caller)
//   advance  in   a granted transfer completed this cycle
//   gnt      out  [1:0] one-hot grant, or zero when nothing is pending
// ----------------------------------------------------------------------------
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    wb_src_e    last_r;
    logic [1:0] gnt_s;

    // Grant selection: a lone request wins outright, a tie goes to the
    // requester other than the one served last.
    always_comb begin
        gnt_s = 2'b00;
        case (req)
            2'b01:   gnt_s = 2'b01;
            2'b10:   gnt_s = 2'b10;
            2'b11:   gnt_s = (last_r == SRC_MEM) ? 2'b01 : 2'b10;
            default: gnt_s = 2'b00;
        endcase
    end

    assign gnt = gnt_s;

    // Last-served pointer: moves only when a grant actually transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r <= SRC_MEM;
        end else if (advance && (gnt_s != 2'b00)) begin
            last_r <= gnt_s[1] ? SRC_MEM : SRC_ALU;
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the single register-file write port between the ALU result
// (requester 0) and the memory load return (requester 1) with round-robin
// arbitration and a valid/ready handshake. The winning write is registered
// and reaches the register file one cycle after acceptance. Writes to $0
// still complete the handshake but are dropped and counted (saturating).
//
// Optional feature, macro WB_BYPASS_EN: adds decode-stage forwarding ports
// (rd_addr1/rd_addr2 in, byp_hit1/byp_hit2/byp_data out) that flag a read
// of the register currently being written.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req0_valid/addr/data      requester 0 (ALU) write request
//   req0_ready                requester 0 accepted this cycle (combinational)
//   req1_valid/addr/data      requester 1 (memory) write request
//   req1_ready                requester 1 accepted this cycle (combinational)
//   hold                      blocks all acceptance (pipeline freeze)
//   wr_en, wr_addr, wr_data   registered register-file write port
//   drop_cnt                  saturating count of dropped $0 writes
// ----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              hold,
`ifdef WB_BYPASS_EN
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              byp_hit1,
    output logic              byp_hit2,
    output logic [DATA_W-1:0] byp_data,
`endif
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [CNT_W-1:0]  drop_cnt
);

    import regfile_pkg::*;

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating increment for the dropped-write counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    logic [1:0]        req_s;
    logic [1:0]        gnt_s;
    logic              xfer_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_data_s;

    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [DATA_W-1:0] wr_data_r;
    logic [CNT_W-1:0]  drop_cnt_r;

    // Requests are only visible to the arbiter outside reset and freeze, so
    // both readies are low in those cycles.
    assign req_s = {req1_valid, req0_valid} & {2{~rst & ~hold}};

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_s),
        .advance (xfer_s),
        .gnt     (gnt_s)
    );

    assign req0_ready = gnt_s[0];
    assign req1_ready = gnt_s[1];

    // A grant is only ever issued to a valid requester, so any grant is a
    // completed handshake.
    assign xfer_s = (gnt_s[0] & req0_valid) | (gnt_s[1] & req1_valid);

    // Address/data of the winning requester.
    always_comb begin
        sel_addr_s = req0_addr;
        sel_data_s = req0_data;
        if (gnt_s[1]) begin
            sel_addr_s = req1_addr;
            sel_data_s = req1_data;
        end else begin
            sel_addr_s = req0_addr;
            sel_data_s = req0_data;
        end
    end

    // Write-port register stage and $0 drop counter. wr_en is a single-cycle
    // pulse per transfer; address/data hold between transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_r    <= 1'b0;
            wr_addr_r  <= '0;
            wr_data_r  <= '0;
            drop_cnt_r <= '0;
        end else if (xfer_s) begin
            wr_addr_r <= sel_addr_s;
            wr_data_r <= sel_data_s;
            if (sel_addr_s == ZERO_ADDR) begin
                wr_en_r    <= 1'b0;
                drop_cnt_r <= sat_inc(drop_cnt_r);
            end else begin
                wr_en_r    <= 1'b1;
                drop_cnt_r <= drop_cnt_r;
            end
        end else begin
            wr_en_r    <= 1'b0;
            wr_addr_r  <= wr_addr_r;
            wr_data_r  <= wr_data_r;
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign wr_en    = wr_en_r;
    assign wr_addr  = wr_addr_r;
    assign wr_data  = wr_data_r;
    assign drop_cnt = drop_cnt_r;

`ifdef WB_BYPASS_EN
    // Forward the in-flight write to decode; $0 never forwards since it
    // always reads as zero.
    assign byp_hit1 = wr_en_r && (wr_addr_r == rd_addr1) && (rd_addr1 != ZERO_ADDR);
    assign byp_hit2 = wr_en_r && (wr_addr_r == rd_addr2) && (rd_addr2 != ZERO_ADDR);
    assign byp_data = wr_data_r;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Table-driven bench for regfile_wb_arbiter: each row is one clock cycle of
// inputs plus the expected readies. Accepted writes are pushed to a
// scoreboard queue and popped one cycle later to check the write port and
// the drop counter. Hand-written sequences cover counter saturation and,
// when WB_BYPASS_EN is defined, the forwarding outputs.
// ----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic          req1_ready;
    logic          hold;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [CW-1:0] drop_cnt;
`ifdef WB_BYPASS_EN
    logic [AW-1:0] rd_addr1;
    logic [AW-1:0] rd_addr2;
    logic          byp_hit1;
    logic          byp_hit2;
    logic [DW-1:0] byp_data;
`endif

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .hold       (hold),
`ifdef WB_BYPASS_EN
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .byp_hit1   (byp_hit1),
        .byp_hit2   (byp_hit2),
        .byp_data   (byp_data),
`endif
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          hold;
        logic          v0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          v1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          r0;
        logic          r1;
    } vec_t;

    vec_t    vecs[$];
    wb_req_t sb[$];

    int total = 0;
    int bad   = 0;

    logic          exp_en;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic [CW-1:0] exp_drop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic h,
                                input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                input logic r0, input logic r1);
        vec_t v;
        v.rst = r;  v.hold = h;
        v.v0 = v0;  v.a0 = a0;  v.d0 = d0;
        v.v1 = v1;  v.a1 = a1;  v.d1 = d1;
        v.r0 = r0;  v.r1 = r1;
        return v;
    endfunction

    // One cycle: drive just after a rising edge, check readies at the falling
    // edge, then check the registered write port just after the next edge.
    task automatic step(input vec_t v, input string tag);
        wb_req_t it;
        rst = v.rst;  hold = v.hold;
        req0_valid = v.v0;  req0_addr = v.a0;  req0_data = v.d0;
        req1_valid = v.v1;  req1_addr = v.a1;  req1_data = v.d1;
        @(negedge clk);
        check({tag, " req0_ready"}, 32'(req0_ready), 32'(v.r0));
        check({tag, " req1_ready"}, 32'(req1_ready), 32'(v.r1));
        if (v.r0 && v.v0) begin
            it.valid = 1'b1;  it.addr = v.a0;  it.data = v.d0;
            sb.push_back(it);
        end else if (v.r1 && v.v1) begin
            it.valid = 1'b1;  it.addr = v.a1;  it.data = v.d1;
            sb.push_back(it);
        end
        @(posedge clk);
        #1;
        if (v.rst) begin
            sb.delete();
            exp_en = 1'b0;  exp_addr = '0;  exp_data = '0;  exp_drop = '0;
        end else if (sb.size() > 0) begin
            it = sb.pop_front();
            exp_addr = it.addr;
            exp_data = it.data;
            exp_en   = (it.addr != 4'h0);
            if ((it.addr == 4'h0) && (exp_drop != 8'hFF)) exp_drop = exp_drop + 8'h01;
        end else begin
            exp_en = 1'b0;
        end
        check({tag, " wr_en"},    32'(wr_en),    32'(exp_en));
        check({tag, " wr_addr"},  32'(wr_addr),  32'(exp_addr));
        check({tag, " wr_data"},  32'(wr_data),  32'(exp_data));
        check({tag, " drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
    endtask

    initial begin
        rst = 1'b1;  hold = 1'b0;
        req0_valid = 1'b0;  req0_addr = '0;  req0_data = '0;
        req1_valid = 1'b0;  req1_addr = '0;  req1_data = '0;
        exp_en = 1'b0;  exp_addr = '0;  exp_data = '0;  exp_drop = '0;
`ifdef WB_BYPASS_EN
        rd_addr1 = '0;  rd_addr2 = '0;
`endif
        //            rst   hold  v0    a0    d0        v1    a1    d1        r0    r1
        // reset with a pending request: no ready, outputs cleared
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 4'h2, 16'h1234, 1'b1, 4'h2, 16'h4321, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0));
        // single request after reset
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 4'h3, 16'hBEEF, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'h3, 16'hBEEF, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0));
        // re-reset so requester 0 wins the first contention
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0));
        // contention: 0 first, then 1
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 4'h5, 16'h1111, 1'b1, 4'h6, 16'h2222, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'h5, 16'h1111, 1'b1, 4'h6, 16'h2222, 1'b0, 1'b1));
        // sustained contention alternates 0,1,0,1
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 4'h5, 16'h3333, 1'b1, 4'h6, 16'h4444, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 4'h5, 16'h5555, 1'b1, 4'h6, 16'h4444, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 4'h5, 16'h5555, 1'b1, 4'h7, 16'h6666, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 4'h7, 16'h6666, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0));
        // three $0 writes from requester 1: handshakes, no wr_en, drop_cnt=3
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 4'h0, 16'hFFFF, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 4'h0, 16'hFFFF, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 4'h0, 16'hFFFF, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0));
        // hold for 3 cycles, accepted once hold falls
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'h7, 16'h7777, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'h7, 16'h7777, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'h7, 16'h7777, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 4'h7, 16'h7777, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0));
        // hold right after an accept: that write still lands
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h0, 16'h0000, 1'b1, 4'h8, 16'h8888, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 4'h8, 16'h8888, 1'b0, 1'b1));
        // same destination from both: grant order, later data lands last
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 4'hA, 16'hAAA1, 1'b1, 4'hA, 16'hAAA2, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 4'hA, 16'hAAA2, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0));
        // reset mid-flight: the request is not accepted, wr_en=0, drop_cnt=0
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 4'h9, 16'h9999, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0));

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // drop counter saturates at 255
        for (int i = 0; i < 260; i++) begin
            step(mk(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 4'h0, 16'h0BAD, 1'b0, 1'b1), "sat");
        end
        check("sat drop_cnt final", 32'(drop_cnt), 32'hFF);
        step(mk(1'b0, 1'b0, 1'b1, 4'h2, 16'h0202, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0), "post_sat");

`ifdef WB_BYPASS_EN
        rd_addr1 = 4'h4;
        rd_addr2 = 4'h0;
        step(mk(1'b0, 1'b0, 1'b1, 4'h4, 16'hCAFE, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0), "byp_w4");
        check("byp_hit1 addr4", 32'(byp_hit1), 32'h1);
        check("byp_data addr4", 32'(byp_data), 32'hCAFE);
        check("byp_hit2 rd0",   32'(byp_hit2), 32'h0);
        rd_addr1 = 4'h5;
        #1;
        check("byp_hit1 other addr", 32'(byp_hit1), 32'h0);
        step(mk(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 4'h0, 16'h1357, 1'b0, 1'b1), "byp_w0");
        check("byp_hit2 addr0", 32'(byp_hit2), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
